// File: rtl/ase_reset_sched_pkg.sv
// Shared ASE reset constants used as parameter defaults by the reset scheduler.
package ase_pkg;
    localparam int unsigned SOFT_RESET_DURATION    = 20;
    localparam int unsigned RESET_TIMEOUT_DURATION = 1024;
    localparam int unsigned TXN_CNT_W              = 10;
endpackage

// File: rtl/ase_reset_sched_if.sv
// Requester/transaction/reset bundle between the ASE reset scheduler and its clients.
interface ase_reset_sched_if #(
    parameter int unsigned NUM_REQ = 4
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_ack;
    logic [IDX_W-1:0]   grant_id;
    logic               busy;
    logic               txn_issue;
    logic               txn_done;
    logic               system_is_idle;
    logic               reset_lockdown;
    logic               soft_reset;
    logic               timed_out;
    logic               cnt_err;

    modport master (
        output req_valid, txn_issue, txn_done,
        input  req_ack, grant_id, busy, system_is_idle, reset_lockdown,
               soft_reset, timed_out, cnt_err
    );

    modport slave (
        input  req_valid, txn_issue, txn_done,
        output req_ack, grant_id, busy, system_is_idle, reset_lockdown,
               soft_reset, timed_out, cnt_err
    );
endinterface

// File: rtl/ase_reset_sched_rr_pick.sv
// Combinational round-robin picker: first set request after i_last, wrapping modulo N.
module ase_rr_pick #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic             o_any,
    output logic [IDX_W-1:0] o_idx,
    output logic [N-1:0]     o_onehot
);
    always_comb begin
        int unsigned      c;
        logic [IDX_W-1:0] w_c;
        o_any    = 1'b0;
        o_idx    = '0;
        o_onehot = '0;
        c        = 0;
        w_c      = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            c = i + 32'(i_last);
            if (c >= N) c = c - N;
            w_c = IDX_W'(c);
            if (!o_any && i_req[w_c]) begin
                o_any         = 1'b1;
                o_idx         = w_c;
                o_onehot[w_c] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/ase_reset_sched.sv
// Round-robin reset scheduler: drain outstanding work, pulse soft reset, settle, then
// acknowledge the granted requester.
module ase_reset_sched
    import ase_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned HOLD_CYCLES    = SOFT_RESET_DURATION,
    parameter int unsigned TIMEOUT_CYCLES = RESET_TIMEOUT_DURATION,
    parameter int unsigned CNT_W          = TXN_CNT_W
) (
    input  logic              clk,
    input  logic              ase_reset,
    ase_reset_sched_if.slave  bus
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned HW    = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [HW-1:0] H_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_HOLD,
        S_SETTLE,
        S_ACK
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_grant;
    logic [NUM_REQ-1:0] r_grant_oh;
    logic [IDX_W-1:0]   r_last;
    logic               r_busy;
    logic               r_lock;
    logic               r_soft;
    logic [NUM_REQ-1:0] r_ack;
    logic               r_tout;
    logic [TW-1:0]      r_tcnt;
    logic [HW-1:0]      r_hcnt;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_idle;
    logic               r_err;

    logic               w_any;
    logic [IDX_W-1:0]   w_pick_idx;
    logic [NUM_REQ-1:0] w_pick_oh;
    logic [TW-1:0]      w_tcnt_inc;
    logic [HW-1:0]      w_hcnt_inc;

    assign w_tcnt_inc = r_tcnt + TW'(1);
    assign w_hcnt_inc = r_hcnt + HW'(1);

    ase_rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_req    (bus.req_valid),
        .i_last   (r_last),
        .o_any    (w_any),
        .o_idx    (w_pick_idx),
        .o_onehot (w_pick_oh)
    );

    // Outstanding-transaction counter; saturates at both ends and flags the attempt.
    always_ff @(posedge clk) begin
        if (ase_reset) begin
            r_cnt  <= '0;
            r_idle <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_idle <= (r_cnt == '0);
            unique case ({bus.txn_issue, bus.txn_done})
                2'b10: if (r_cnt == '1) r_err <= 1'b1; else r_cnt <= r_cnt + CNT_W'(1);
                2'b01: if (r_cnt == '0) r_err <= 1'b1; else r_cnt <= r_cnt - CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (ase_reset) begin
            r_state    <= S_IDLE;
            r_grant    <= '0;
            r_grant_oh <= '0;
            r_last     <= IDX_W'(NUM_REQ - 1);
            r_busy     <= 1'b0;
            r_lock     <= 1'b1;
            r_soft     <= 1'b1;
            r_ack      <= '0;
            r_tout     <= 1'b0;
            r_tcnt     <= '0;
            r_hcnt     <= '0;
        end else begin
            r_ack  <= '0;
            r_tout <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    r_soft <= 1'b0;
                    r_lock <= 1'b0;
                    r_busy <= 1'b0;
                    if (w_any) begin
                        r_state    <= S_DRAIN;
                        r_grant    <= w_pick_idx;
                        r_grant_oh <= w_pick_oh;
                        r_last     <= w_pick_idx;
                        r_busy     <= 1'b1;
                        r_lock     <= 1'b1;
                        r_tcnt     <= '0;
                        r_tout     <= (TIMEOUT_CYCLES == 1) && (r_cnt != '0);
                    end
                end
                // timed_out is raised one edge early so it coincides with the last DRAIN
                // cycle; r_cnt now is what system_is_idle will show in that cycle.
                S_DRAIN: begin
                    if (r_idle || (r_tcnt == T_LAST)) begin
                        r_state <= S_HOLD;
                        r_soft  <= 1'b1;
                        r_hcnt  <= '0;
                    end else begin
                        r_tcnt <= w_tcnt_inc;
                        r_tout <= (w_tcnt_inc == T_LAST) && (r_cnt != '0);
                    end
                end
                S_HOLD: begin
                    if (r_hcnt == H_LAST) begin
                        r_state <= S_SETTLE;
                        r_soft  <= 1'b0;
                        r_hcnt  <= '0;
                    end else begin
                        r_hcnt <= w_hcnt_inc;
                    end
                end
                S_SETTLE: begin
                    if (r_hcnt == H_LAST) begin
                        r_state <= S_ACK;
                        r_lock  <= 1'b0;
                        r_ack   <= r_grant_oh;
                    end else begin
                        r_hcnt <= w_hcnt_inc;
                    end
                end
                S_ACK: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ack        = r_ack;
    assign bus.grant_id       = r_grant;
    assign bus.busy           = r_busy;
    assign bus.system_is_idle = r_idle;
    assign bus.reset_lockdown = r_lock;
    assign bus.soft_reset     = r_soft;
    assign bus.timed_out      = r_tout;
    assign bus.cnt_err        = r_err;
endmodule

// File: tb/tb_ase_reset_sched.sv
// Directed bench for ase_reset_sched with HOLD_CYCLES=20 and TIMEOUT_CYCLES=16.
module tb_ase_reset_sched;
    logic clk = 1'b0;
    logic ase_reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    ase_reset_sched_if #(.NUM_REQ(4)) bus ();

    ase_reset_sched #(
        .NUM_REQ        (4),
        .HOLD_CYCLES    (20),
        .TIMEOUT_CYCLES (16),
        .CNT_W          (10)
    ) dut (
        .clk       (clk),
        .ase_reset (ase_reset),
        .bus       (bus)
    );

    task automatic do_reset();
        ase_reset = 1'b1;
        bus.req_valid = '0;
        bus.txn_issue = 1'b0;
        bus.txn_done  = 1'b0;
        repeat (2) @(negedge clk);
        ase_reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        ase_reset = 1'b1;
        bus.req_valid = '0;
        bus.txn_issue = 1'b0;
        bus.txn_done  = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({bus.soft_reset, bus.reset_lockdown, bus.system_is_idle, bus.busy, bus.timed_out, bus.cnt_err} !== 6'b110000) begin
            $display("FAIL reset_flags got %b exp 110000", {bus.soft_reset, bus.reset_lockdown, bus.system_is_idle, bus.busy, bus.timed_out, bus.cnt_err});
            n_fail++;
        end
        n_tests++;
        if ({bus.req_ack, bus.grant_id} !== 6'b0) begin
            $display("FAIL reset_ack_grant got %b exp 000000", {bus.req_ack, bus.grant_id});
            n_fail++;
        end
        ase_reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({bus.soft_reset, bus.reset_lockdown, bus.system_is_idle} !== 3'b001) begin
            $display("FAIL post_reset got %b exp 001", {bus.soft_reset, bus.reset_lockdown, bus.system_is_idle});
            n_fail++;
        end
    endtask

    task automatic test_single();
        logic       e_soft, e_lock, e_busy;
        logic [3:0] e_ack;
        bus.req_valid = 4'b0010;
        for (int k = 1; k <= 43; k++) begin
            @(negedge clk);
            e_soft = (k >= 2 && k <= 21);
            e_lock = (k <= 41);
            e_busy = (k <= 42);
            e_ack  = (k == 42) ? 4'b0010 : 4'b0000;
            n_tests++;
            if ({bus.soft_reset, bus.reset_lockdown, bus.busy, bus.req_ack, bus.timed_out} !== {e_soft, e_lock, e_busy, e_ack, 1'b0}) begin
                $display("FAIL single k=%0d soft/lock/busy/ack/tout got %b exp %b", k,
                         {bus.soft_reset, bus.reset_lockdown, bus.busy, bus.req_ack, bus.timed_out}, {e_soft, e_lock, e_busy, e_ack, 1'b0});
                n_fail++;
            end
            if (k == 1) begin
                n_tests++;
                if (bus.grant_id !== 2'd1) begin
                    $display("FAIL single_grant got %0d exp 1", bus.grant_id);
                    n_fail++;
                end
            end
            if (k == 42) bus.req_valid = '0;
        end
    endtask

    task automatic test_drain();
        logic       e_soft, e_lock, e_idle;
        logic [3:0] e_ack;
        repeat (3) begin
            @(negedge clk);
            bus.txn_issue = 1'b1;
        end
        @(negedge clk);
        bus.txn_issue = 1'b0;
        bus.req_valid = 4'b0001;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            e_soft = (k >= 9 && k <= 28);
            e_lock = (k <= 48);
            e_idle = (k >= 8);
            e_ack  = (k == 49) ? 4'b0001 : 4'b0000;
            n_tests++;
            if ({bus.soft_reset, bus.reset_lockdown, bus.system_is_idle, bus.req_ack, bus.timed_out} !== {e_soft, e_lock, e_idle, e_ack, 1'b0}) begin
                $display("FAIL drain k=%0d soft/lock/idle/ack/tout got %b exp %b", k,
                         {bus.soft_reset, bus.reset_lockdown, bus.system_is_idle, bus.req_ack, bus.timed_out}, {e_soft, e_lock, e_idle, e_ack, 1'b0});
                n_fail++;
            end
            if (k == 1) begin
                n_tests++;
                if (bus.grant_id !== 2'd0) begin
                    $display("FAIL drain_grant got %0d exp 0", bus.grant_id);
                    n_fail++;
                end
            end
            bus.txn_done = (k == 2 || k == 4 || k == 6);
            if (k == 49) bus.req_valid = '0;
        end
    endtask

    task automatic test_timeout();
        logic       e_soft, e_tout;
        logic [3:0] e_ack;
        @(negedge clk);
        bus.txn_issue = 1'b1;
        @(negedge clk);
        bus.txn_issue = 1'b0;
        bus.req_valid = 4'b0100;
        for (int k = 1; k <= 58; k++) begin
            @(negedge clk);
            e_soft = (k >= 17 && k <= 36);
            e_tout = (k == 16);
            e_ack  = (k == 57) ? 4'b0100 : 4'b0000;
            n_tests++;
            if ({bus.soft_reset, bus.timed_out, bus.req_ack, bus.cnt_err} !== {e_soft, e_tout, e_ack, 1'b0}) begin
                $display("FAIL timeout k=%0d soft/tout/ack/err got %b exp %b", k,
                         {bus.soft_reset, bus.timed_out, bus.req_ack, bus.cnt_err}, {e_soft, e_tout, e_ack, 1'b0});
                n_fail++;
            end
            if (k == 1) begin
                n_tests++;
                if (bus.grant_id !== 2'd2) begin
                    $display("FAIL timeout_grant got %0d exp 2", bus.grant_id);
                    n_fail++;
                end
            end
            bus.txn_done = (k == 57);
            if (k == 57) bus.req_valid = '0;
        end
        bus.txn_done = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [3:0] e_ack;
        do_reset();
        bus.req_valid = 4'b1111;
        for (int k = 1; k <= 215; k++) begin
            @(negedge clk);
            e_ack = 4'b0000;
            if (k >= 42 && (k - 42) % 43 == 0) e_ack = 4'b0001 << (((k - 42) / 43) % 4);
            n_tests++;
            if (bus.req_ack !== e_ack) begin
                $display("FAIL rr_ack k=%0d got %b exp %b", k, bus.req_ack, e_ack);
                n_fail++;
            end
            if (k == 43 || k == 44) begin
                n_tests++;
                if (bus.busy !== (k == 44)) begin
                    $display("FAIL rr_busy k=%0d got %b exp %b", k, bus.busy, (k == 44));
                    n_fail++;
                end
            end
            if (k == 214) bus.req_valid = '0;
        end
    endtask

    task automatic test_counter_edges();
        repeat (5) begin
            @(negedge clk);
            bus.txn_issue = 1'b1;
            bus.txn_done  = 1'b0;
        end
        @(negedge clk);
        bus.txn_done = 1'b1;
        repeat (4) begin
            @(negedge clk);
            bus.txn_issue = 1'b0;
            bus.txn_done  = 1'b1;
        end
        @(negedge clk);
        bus.txn_done = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({bus.system_is_idle, bus.cnt_err} !== 2'b00) begin
            $display("FAIL cnt_at_one idle/err got %b exp 00", {bus.system_is_idle, bus.cnt_err});
            n_fail++;
        end
        bus.txn_done = 1'b1;
        @(negedge clk);
        bus.txn_done = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({bus.system_is_idle, bus.cnt_err} !== 2'b10) begin
            $display("FAIL cnt_at_zero idle/err got %b exp 10", {bus.system_is_idle, bus.cnt_err});
            n_fail++;
        end
        bus.txn_done = 1'b1;
        @(negedge clk);
        bus.txn_done = 1'b0;
        n_tests++;
        if (bus.cnt_err !== 1'b1) begin
            $display("FAIL cnt_underflow err got %b exp 1", bus.cnt_err);
            n_fail++;
        end
        @(negedge clk);
        n_tests++;
        if ({bus.system_is_idle, bus.cnt_err} !== 2'b11) begin
            $display("FAIL cnt_underflow_hold idle/err got %b exp 11", {bus.system_is_idle, bus.cnt_err});
            n_fail++;
        end
    endtask

    task automatic test_midseq_reset();
        bus.req_valid = 4'b0100;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) begin
                n_tests++;
                if (bus.grant_id !== 2'd2) begin
                    $display("FAIL mid_grant got %0d exp 2", bus.grant_id);
                    n_fail++;
                end
            end
        end
        n_tests++;
        if (bus.soft_reset !== 1'b1) begin
            $display("FAIL mid_in_hold soft got %b exp 1", bus.soft_reset);
            n_fail++;
        end
        ase_reset = 1'b1;
        bus.req_valid = '0;
        @(negedge clk);
        n_tests++;
        if ({bus.soft_reset, bus.reset_lockdown, bus.system_is_idle, bus.busy, bus.timed_out, bus.cnt_err, bus.req_ack, bus.grant_id} !== 12'b110000_0000_00) begin
            $display("FAIL mid_reset_vals got %b exp 110000000000",
                     {bus.soft_reset, bus.reset_lockdown, bus.system_is_idle, bus.busy, bus.timed_out, bus.cnt_err, bus.req_ack, bus.grant_id});
            n_fail++;
        end
        ase_reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_tests++;
            if ({bus.req_ack, bus.busy, bus.soft_reset, bus.reset_lockdown, bus.system_is_idle} !== 8'b0000_0001) begin
                $display("FAIL mid_after k=%0d ack/busy/soft/lock/idle got %b exp 00000001", k,
                         {bus.req_ack, bus.busy, bus.soft_reset, bus.reset_lockdown, bus.system_is_idle});
                n_fail++;
            end
        end
        bus.req_valid = 4'b1001;
        for (int k = 1; k <= 43; k++) begin
            @(negedge clk);
            if (k == 1) begin
                n_tests++;
                if (bus.grant_id !== 2'd0) begin
                    $display("FAIL mid_next_grant got %0d exp 0", bus.grant_id);
                    n_fail++;
                end
            end
            if (k == 42) begin
                n_tests++;
                if (bus.req_ack !== 4'b0001) begin
                    $display("FAIL mid_next_ack got %b exp 0001", bus.req_ack);
                    n_fail++;
                end
                bus.req_valid = '0;
            end
        end
    endtask

    task automatic test_saturate();
        repeat (1023) begin
            @(negedge clk);
            bus.txn_issue = 1'b1;
        end
        @(negedge clk);
        n_tests++;
        if (bus.cnt_err !== 1'b0) begin
            $display("FAIL sat_before err got %b exp 0", bus.cnt_err);
            n_fail++;
        end
        @(negedge clk);
        bus.txn_issue = 1'b0;
        n_tests++;
        if (bus.cnt_err !== 1'b1) begin
            $display("FAIL sat_overflow err got %b exp 1", bus.cnt_err);
            n_fail++;
        end
        repeat (1022) begin
            @(negedge clk);
            bus.txn_done = 1'b1;
        end
        @(negedge clk);
        bus.txn_done = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.system_is_idle !== 1'b0) begin
            $display("FAIL sat_one_left idle got %b exp 0", bus.system_is_idle);
            n_fail++;
        end
        bus.txn_done = 1'b1;
        @(negedge clk);
        bus.txn_done = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.system_is_idle !== 1'b1) begin
            $display("FAIL sat_drained idle got %b exp 1", bus.system_is_idle);
            n_fail++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_drain();
        test_timeout();
        test_round_robin();
        test_counter_edges();
        test_midseq_reset();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
